// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: shares one combinational-read instruction ROM between the
// instruction-fetch port (IF) and the data-section read port (DS). One access
// is granted per cycle. The ROM word comes back one cycle later with a single
// cycle valid strobe, and misaligned or out-of-range addresses are flagged.
module rom_read_arbiter #(
  parameter int DEPTH  = 256,
  parameter int ABITS  = 32,
  parameter int DWIDTH = 32,
  parameter int RR_EN  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ABITS-1:0]  if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DWIDTH-1:0] if_rdata,
  output logic              if_err,
  input  logic              ds_req,
  input  logic [ABITS-1:0]  ds_addr,
  output logic              ds_gnt,
  output logic              ds_rvalid,
  output logic [DWIDTH-1:0] ds_rdata,
  output logic              ds_err,
  output logic [ABITS-1:0]  rom_adr,
  input  logic [DWIDTH-1:0] rom_dout
);

  localparam logic [ABITS-1:0] DEPTH_W = ABITS'(DEPTH);

  logic              r_last_ds;   // 1 = DS was the most recent grant
  logic [ABITS-1:0]  r_adr_hold;
  logic              r_if_rvalid;
  logic [DWIDTH-1:0] r_if_rdata;
  logic              r_if_err;
  logic              r_ds_rvalid;
  logic [DWIDTH-1:0] r_ds_rdata;
  logic              r_ds_err;

  logic              w_if_gnt;
  logic              w_ds_gnt;
  logic              w_any_gnt;
  logic [ABITS-1:0]  w_gnt_addr;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic              w_illegal;

  // Arbitration; grants are forced low while reset is asserted.
  always_comb begin
    w_if_gnt = 1'b0;
    w_ds_gnt = 1'b0;
    if (reset_n) begin
      if (if_req && ds_req) begin
        if ((RR_EN != 0) && !r_last_ds) begin
          w_ds_gnt = 1'b1;
        end else begin
          w_if_gnt = 1'b1;
        end
      end else begin
        w_if_gnt = if_req;
        w_ds_gnt = ds_req;
      end
    end
  end

  // ROM address: the granted port's address, else the last granted one so it stays glitch-free.
  always_comb begin
    w_gnt_addr = r_adr_hold;
    if (w_if_gnt) begin
      w_gnt_addr = if_addr;
    end else if (w_ds_gnt) begin
      w_gnt_addr = ds_addr;
    end
  end

  assign w_any_gnt      = w_if_gnt | w_ds_gnt;
  assign w_misaligned   = (w_gnt_addr[1:0] != 2'b00);
  // Word index is compared at full address width so high address bits are never dropped.
  assign w_out_of_range = ({2'b00, w_gnt_addr[ABITS-1:2]} >= DEPTH_W);
  assign w_illegal      = w_misaligned | w_out_of_range;

  // Round-robin pointer and held ROM address, updated only on granted cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_ds  <= 1'b1;
      r_adr_hold <= '0;
    end else if (w_any_gnt) begin
      r_last_ds  <= w_ds_gnt;
      r_adr_hold <= w_gnt_addr;
    end
  end

  // Registered responses: valid pulses for one cycle, data/err hold until that port's next response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_if_err    <= 1'b0;
      r_ds_rvalid <= 1'b0;
      r_ds_rdata  <= '0;
      r_ds_err    <= 1'b0;
    end else begin
      r_if_rvalid <= w_if_gnt;
      r_ds_rvalid <= w_ds_gnt;
      if (w_if_gnt) begin
        r_if_rdata <= w_illegal ? '0 : rom_dout;
        r_if_err   <= w_illegal;
      end
      if (w_ds_gnt) begin
        r_ds_rdata <= w_illegal ? '0 : rom_dout;
        r_ds_err   <= w_illegal;
      end
    end
  end

  assign if_gnt    = w_if_gnt;
  assign ds_gnt    = w_ds_gnt;
  assign rom_adr   = w_gnt_addr;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign if_err    = r_if_err;
  assign ds_rvalid = r_ds_rvalid;
  assign ds_rdata  = r_ds_rdata;
  assign ds_err    = r_ds_err;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Testbench for rom_read_arbiter: a round-robin instance and a fixed-priority
// instance share the same request stimulus. A behavioural model checks every
// cycle, and a vector table plus hand-written sequences cover the corner cases.
module tb_rom_read_arbiter;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        ds_req = 1'b0;
  logic [31:0] ds_addr = '0;

  logic [1:0]  w_if_gnt, w_if_rvalid, w_if_err;
  logic [1:0]  w_ds_gnt, w_ds_rvalid, w_ds_err;
  logic [31:0] w_if_rdata [2];
  logic [31:0] w_ds_rdata [2];
  logic [31:0] w_rom_adr  [2];
  logic [31:0] w_rom_dout [2];

  int checks = 0;
  int errors = 0;

  // model state per instance (0 = round-robin, 1 = fixed priority)
  bit          m_last_ds [2];
  logic [31:0] m_adr     [2];
  logic        e_if_v [2], e_if_e [2], e_ds_v [2], e_ds_e [2];
  logic [31:0] e_if_d [2], e_ds_d [2];
  int          dut_g   [2];
  logic [31:0] dut_adr [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] idx);
    if (idx == 32'd2) return 32'h2008_0005;
    if (idx >= DEPTH) return 32'hBAD0_BAD0;
    return 32'h1357_2468 + idx * 32'h0100_0193;
  endfunction

  assign w_rom_dout[0] = rom_word(w_rom_adr[0] >> 2);
  assign w_rom_dout[1] = rom_word(w_rom_adr[1] >> 2);

  rom_read_arbiter #(.DEPTH(DEPTH), .ABITS(32), .DWIDTH(32), .RR_EN(1)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(w_if_gnt[0]), .if_rvalid(w_if_rvalid[0]),
    .if_rdata(w_if_rdata[0]), .if_err(w_if_err[0]),
    .ds_req(ds_req), .ds_addr(ds_addr), .ds_gnt(w_ds_gnt[0]), .ds_rvalid(w_ds_rvalid[0]),
    .ds_rdata(w_ds_rdata[0]), .ds_err(w_ds_err[0]),
    .rom_adr(w_rom_adr[0]), .rom_dout(w_rom_dout[0]));

  rom_read_arbiter #(.DEPTH(DEPTH), .ABITS(32), .DWIDTH(32), .RR_EN(0)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(w_if_gnt[1]), .if_rvalid(w_if_rvalid[1]),
    .if_rdata(w_if_rdata[1]), .if_err(w_if_err[1]),
    .ds_req(ds_req), .ds_addr(ds_addr), .ds_gnt(w_ds_gnt[1]), .ds_rvalid(w_ds_rvalid[1]),
    .ds_rdata(w_ds_rdata[1]), .ds_err(w_ds_err[1]),
    .rom_adr(w_rom_adr[1]), .rom_dout(w_rom_dout[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 0 = none, 1 = IF, 2 = DS
  function automatic int model_grant(input int inst, input bit ir, input bit dr);
    if (ir && !dr) return 1;
    if (dr && !ir) return 2;
    if (!ir && !dr) return 0;
    if (inst == 1) return 1;
    return m_last_ds[inst] ? 1 : 2;
  endfunction

  function automatic bit addr_legal(input logic [31:0] a);
    return (a % 4 == 0) && ((a / 4) < DEPTH);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last_ds[k] = 1'b1;
      m_adr[k] = '0;
      e_if_v[k] = 0; e_if_e[k] = 0; e_if_d[k] = '0;
      e_ds_v[k] = 0; e_ds_e[k] = 0; e_ds_d[k] = '0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_gnt"}, {w_if_gnt[k], w_ds_gnt[k]}, 2'b00);
      chk({tag, "_rvalid"}, {w_if_rvalid[k], w_ds_rvalid[k]}, 2'b00);
      chk({tag, "_err"}, {w_if_err[k], w_ds_err[k]}, 2'b00);
      chk({tag, "_if_rdata"}, w_if_rdata[k], 0);
      chk({tag, "_ds_rdata"}, w_ds_rdata[k], 0);
      chk({tag, "_rom_adr"}, w_rom_adr[k], 0);
    end
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic cycle();
    int g [2];
    logic [31:0] ga [2];
    #2;
    for (int k = 0; k < 2; k++) begin
      g[k] = model_grant(k, if_req, ds_req);
      ga[k] = (g[k] == 1) ? if_addr : (g[k] == 2) ? ds_addr : m_adr[k];
      dut_g[k] = w_if_gnt[k] ? 1 : (w_ds_gnt[k] ? 2 : 0);
      dut_adr[k] = w_rom_adr[k];
      chk("m_if_gnt", w_if_gnt[k], g[k] == 1);
      chk("m_ds_gnt", w_ds_gnt[k], g[k] == 2);
      chk("m_rom_adr", w_rom_adr[k], ga[k]);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      e_if_v[k] = (g[k] == 1);
      e_ds_v[k] = (g[k] == 2);
      if (g[k] != 0) begin
        m_last_ds[k] = (g[k] == 2);
        m_adr[k] = ga[k];
      end
      if (g[k] == 1) begin
        e_if_e[k] = !addr_legal(ga[k]);
        e_if_d[k] = addr_legal(ga[k]) ? rom_word(ga[k] / 4) : 32'h0;
      end
      if (g[k] == 2) begin
        e_ds_e[k] = !addr_legal(ga[k]);
        e_ds_d[k] = addr_legal(ga[k]) ? rom_word(ga[k] / 4) : 32'h0;
      end
      chk("m_if_rvalid", w_if_rvalid[k], e_if_v[k]);
      chk("m_ds_rvalid", w_ds_rvalid[k], e_ds_v[k]);
      chk("m_if_rdata", w_if_rdata[k], e_if_d[k]);
      chk("m_ds_rdata", w_ds_rdata[k], e_ds_d[k]);
      chk("m_if_err", w_if_err[k], e_if_e[k]);
      chk("m_ds_err", w_ds_err[k], e_ds_e[k]);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [31:0] da;
    int          eg_rr;
    int          eg_fp;
    logic [31:0] eadr;
    logic        eifv;
    logic        edsv;
    logic        eerr;
  } vec_t;

  vec_t tbl [$];

  initial begin
    // ir  ia        dr  da        rr fp adr       ifv dsv err
    tbl.push_back('{1, 32'h008, 0, 32'h000, 1, 1, 32'h008, 1, 0, 0});
    tbl.push_back('{0, 32'h000, 1, 32'h3FC, 2, 2, 32'h3FC, 0, 1, 0});
    tbl.push_back('{1, 32'h000, 1, 32'h040, 1, 1, 32'h000, 1, 0, 0});
    tbl.push_back('{1, 32'h000, 1, 32'h040, 2, 1, 32'h040, 0, 1, 0});
    tbl.push_back('{1, 32'h000, 1, 32'h040, 1, 1, 32'h000, 1, 0, 0});
    tbl.push_back('{1, 32'h000, 1, 32'h040, 2, 1, 32'h040, 0, 1, 0});
    tbl.push_back('{0, 32'h000, 1, 32'h040, 2, 2, 32'h040, 0, 1, 0});
    tbl.push_back('{0, 32'h000, 1, 32'h042, 2, 2, 32'h042, 0, 1, 1});
    tbl.push_back('{0, 32'h000, 1, 32'h400, 2, 2, 32'h400, 0, 1, 1});
    tbl.push_back('{0, 32'h000, 0, 32'h000, 0, 0, 32'h400, 0, 0, 0});
    tbl.push_back('{0, 32'h000, 1, 32'h000, 2, 2, 32'h000, 0, 1, 0});
    tbl.push_back('{0, 32'h000, 1, 32'h004, 2, 2, 32'h004, 0, 1, 0});
    tbl.push_back('{0, 32'h000, 1, 32'h008, 2, 2, 32'h008, 0, 1, 0});
    tbl.push_back('{0, 32'h000, 0, 32'h000, 0, 0, 32'h008, 0, 0, 0});

    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      if_req = tbl[i].ir; if_addr = tbl[i].ia;
      ds_req = tbl[i].dr; ds_addr = tbl[i].da;
      cycle();
      chk("tbl_gnt_rr", dut_g[0], tbl[i].eg_rr);
      chk("tbl_gnt_fp", dut_g[1], tbl[i].eg_fp);
      chk("tbl_rom_adr", dut_adr[0], tbl[i].eadr);
      chk("tbl_if_rvalid", w_if_rvalid[0], tbl[i].eifv);
      chk("tbl_ds_rvalid", w_ds_rvalid[0], tbl[i].edsv);
      if (tbl[i].edsv) chk("tbl_ds_err", w_ds_err[0], tbl[i].eerr);
      else if (tbl[i].eifv) chk("tbl_if_err", w_if_err[0], tbl[i].eerr);
      if (i == 0) chk("if_fetch_rdata", w_if_rdata[0], 32'h2008_0005);
      if (i == 1) chk("ds_word255", w_ds_rdata[0], rom_word(255));
      if (i == 3) chk("ds_word16", w_ds_rdata[0], rom_word(16));
      if (i == 7) chk("ds_misalign_rdata", w_ds_rdata[0], 32'h0);
      if (i >= 10 && i <= 12) chk("ds_b2b_word", w_ds_rdata[0], rom_word(i - 10));
    end

    // Reset while an IF grant is in flight: the response must be dropped.
    if_req = 1'b1; if_addr = 32'h10; ds_req = 1'b0;
    #2;
    chk("midrst_if_gnt", w_if_gnt[0], 1'b1);
    #2;
    reset_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("midrst_no_rvalid", w_if_rvalid[0], 1'b0);
    chk_all_zero("midrst");
    @(negedge clk);
    ds_req = 1'b1; ds_addr = 32'h20;
    chk_all_zero("midrst_hold");
    reset_n = 1'b1;
    cycle();
    chk("rel_if_first", dut_g[0], 1);
    cycle();
    chk("rel_ds_second", dut_g[0], 2);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      if_req = ($urandom_range(0, 3) != 0);
      ds_req = ($urandom_range(0, 2) != 0);
      for (int p = 0; p < 2; p++) begin
        logic [31:0] a;
        case ($urandom_range(0, 9))
          0:       a = $urandom;
          1:       a = ($urandom_range(0, 300) << 2) | $urandom_range(1, 3);
          2:       a = $urandom_range(250, 270) << 2;
          default: a = $urandom_range(0, DEPTH - 1) << 2;
        endcase
        if (p == 0) if_addr = a; else ds_addr = a;
      end
      cycle();
    end

    if_req = 1'b0; ds_req = 1'b0;
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Shares the single combinational-read instruction ROM between two requesters.
  - Instruction fetch port (IF).
  - Data-section read port (DS), which serves loads from constant/data words stored in the ROM image.
- Grants at most one access per cycle, drives the ROM address, registers the ROM word and returns it one cycle later with a valid strobe.
- Sits between the fetch/load units and the ROM; also flags misaligned and out-of-range addresses.

Parameters:
- DEPTH, 256, number of 32-bit words in the ROM; the valid byte-address range is 0 .. 4*DEPTH-1.
- ABITS, 32, byte-address width of requester and ROM address ports.
- DWIDTH, 32, data word width.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with IF always winning.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high with if_addr stable until if_gnt.
- if_addr  in  ABITS  fetch byte address.
- if_gnt  out  1  combinational grant to the fetch port this cycle.
- if_rvalid  out  1  registered; fetch data/err valid for one cycle.
- if_rdata  out  DWIDTH  registered fetch data.
- if_err  out  1  registered; qualifies if_rvalid, marks a misaligned or out-of-range access.
- ds_req, ds_addr, ds_gnt, ds_rvalid, ds_rdata, ds_err: same definitions for the data-section port.
- rom_adr  out  ABITS  byte address to the ROM; the ROM indexes adr/4.
- rom_dout  in  DWIDTH  combinational ROM read data.

Behaviour:
- Reset (async assert, sync release). While reset_n = 0:
  - if_gnt, ds_gnt, both rvalid, both err = 0.
  - Both rdata = 0.
  - rom_adr = 0.
  - Round-robin pointer last = DS, so IF wins the first contention.
- Reset mid-operation: a response pending for the next edge is discarded; no rvalid follows reset release.
- Arbitration (combinational, each cycle):
  - Only IF requests: if_gnt = 1.
  - Only DS requests: ds_gnt = 1.
  - Both request, RR_EN = 1: grant the port not equal to last.
  - Both request, RR_EN = 0: grant IF.
  - No requests: no grant; rom_adr holds its last granted address, giving no glitch.
  - At most one gnt is high in any cycle.
- Pointer update:
  - last <= granted port on every cycle with a grant; unchanged on idle cycles.
  - Under continuous contention the grants strictly alternate IF, DS, IF, ...
- Address path:
  - rom_adr = granted port's address in the same cycle.
  - Address check on the granted address:
    - misaligned = addr[1:0] != 0.
    - out-of-range = addr[ABITS-1:2] >= DEPTH, compared at full width with no truncation.
- Response (latency 1):
  - On the edge ending a grant cycle, the granted port's rvalid <= 1 and the other port's rvalid <= 0.
  - Legal address: rdata <= rom_dout and err <= 0.
  - Illegal address: rdata <= 0 and err <= 1.
- Outputs between responses:
  - rvalid is a single-cycle pulse per grant.
  - rdata and err hold their values until the next response to that port.
- Back-to-back: the same port may be granted in consecutive cycles and receives consecutive rvalid pulses, giving one word per cycle with no bubble.
- Requester rules:
  - Deasserting req before gnt is legal; no access occurs.
  - Address changes before gnt are legal; the address present in the grant cycle is used.
- Simultaneous reset release and req: the grant is decided in the first cycle with reset_n = 1.
- State: the last pointer, two registered response sets and the held rom_adr. No other FSM.

Test Plan:
- IF-only fetch: after reset, if_req = 1, if_addr = 0x00000008, ROM word 2 = 0x20080005.
  - Required: if_gnt in cycle 0, rom_adr = 0x8.
  - Required: in cycle 1, if_rvalid = 1, if_rdata = 0x20080005, if_err = 0.
- Contention, RR_EN = 1: both req held for 4 cycles, if_addr = 0x0, ds_addr = 0x40.
  - Required grant order: IF, DS, IF, DS.
  - Required: rvalid pulses alternate one cycle later.
  - Required: ds_rdata = ROM word 16.
- Fixed priority, RR_EN = 0: both req held for 3 cycles.
  - Required: if_gnt every cycle, ds_gnt never asserted.
  - Required: after if_req drops, ds_gnt asserts in that same cycle.
- Errors:
  - ds_addr = 0x42 → ds_rvalid = 1, ds_err = 1, ds_rdata = 0.
  - ds_addr = 0x400 with DEPTH = 256 → ds_err = 1.
  - ds_addr = 0x3FC → ds_err = 0 and ds_rdata = ROM word 255.
- Reset mid-operation: grant IF in cycle N, assert reset_n = 0 before the edge.
  - Required: no if_rvalid.
  - Required: all outputs read 0 during reset.
  - Required: on release with both requesting, IF is granted first.
- Back-to-back DS: ds_req held 3 cycles, addresses 0x0, 0x4, 0x8.
  - Required: ds_rvalid high for 3 consecutive cycles with ROM words 0, 1, 2 in order.
